// File: rtl/fpdp_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one double-precision adder among
// NREQ requesters. Operands and result pass through bit-exact.
module fpdp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rset,
  input  logic [NREQ-1:0]      req,
  input  logic [64*NREQ-1:0]   opa,
  input  logic [64*NREQ-1:0]   opb,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_z,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [63:0]          add_a,
  output logic [63:0]          add_b,
  output logic                 add_start,
  input  logic                 add_done,
  input  logic [63:0]          add_z
);

  localparam int          IW     = $clog2(NREQ);
  localparam int          TW     = $clog2(TIMEOUT);
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   timer;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  logic [63:0]     opa_w [NREQ];
  logic [63:0]     opb_w [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign opa_w[g] = opa[64*g +: 64];
    assign opb_w[g] = opb[64*g +: 64];
  end

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin search: first asserted request above last_grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ_U; i++) begin
      cand = IW'((32'(last_grant) + i) % NREQ_U);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant pulses in the same IDLE cycle that samples req, so it is the one
  // output decoded from state and the arbitration result.
  always_comb begin
    gnt = '0;
    if (state == IDLE && win_found) gnt = onehot(win_idx);
  end

  // Sequencer: grant/capture, issue start, wait with watchdog, respond.
  always_ff @(posedge clk) begin
    if (rset) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      idx        <= '0;
      timer      <= '0;
      rsp_valid  <= '0;
      rsp_z      <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_start  <= 1'b0;
    end else begin
      add_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            add_a     <= opa_w[win_idx];
            add_b     <= opb_w[win_idx];
            idx       <= win_idx;
            add_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (add_done) begin
            rsp_z     <= add_z;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(idx);
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
            // Abort on the cycle the count would reach TIMEOUT-1, so the
            // error response lands exactly TIMEOUT cycles after the start.
            if (timer == TW'(TIMEOUT - 2)) begin
              rsp_z     <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= onehot(idx);
              state     <= RESP;
            end
          end
        end
        RESP: begin
          last_grant <= idx;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdp_add_arbiter.sv
// Randomized self-checking bench for fpdp_add_arbiter with a behavioural
// adder and a round-robin reference model.
module tb_fpdp_add_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  typedef struct { int cyc; int idx; } gev_t;
  typedef struct { int cyc; int idx; logic [63:0] z; logic err; } rev_t;

  logic                 clk = 1'b0;
  logic                 rset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [64*NREQ-1:0]   opa;
  logic [64*NREQ-1:0]   opb;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [63:0]          rsp_z;
  logic                 rsp_err;
  logic                 busy;
  logic [63:0]          add_a;
  logic [63:0]          add_b;
  logic                 add_start;
  logic                 add_done = 1'b0;
  logic [63:0]          add_z = '0;

  logic [63:0] opa_r [NREQ];
  logic [63:0] opb_r [NREQ];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;
  int model_lg;

  gev_t g_q[$];
  rev_t rsp_q[$];
  int   start_q[$];

  int          adder_lat = 1;
  int          stray_cnt = 0;
  int          stray_seen = 0;
  logic [63:0] stray_z = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [63:0] res = '0;

  bit   op_ok;
  gev_t op_g;
  rev_t op_r;
  int   op_s;
  int   op_reqcyc;

  fpdp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rset(rset), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_done(add_done), .add_z(add_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      opa[i*64 +: 64] = opa_r[i];
      opb[i*64 +: 64] = opb_r[i];
    end
  end

  function automatic logic [63:0] fsum(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      logic [NREQ-1:0] t;
      t = v >> i;
      if (t[0]) return i;
    end
    return -1;
  endfunction

  // Reference arbitration: first requester after the last winner, modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] m, input int lg);
    for (int k = 1; k <= NREQ; k++) begin
      logic [NREQ-1:0] t;
      t = m >> ((lg + k) % NREQ);
      if (t[0]) return (lg + k) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural adder: done pulse adder_lat cycles after add_start (0 = never).
  always @(negedge clk) begin
    add_done = 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        add_done = 1'b1;
        add_z    = res;
        pend     = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (stray_cnt != stray_seen) begin
      add_done = 1'b1;
      add_z    = stray_z;
      stray_seen++;
    end
    if (add_start && adder_lat > 0) begin
      pend = 1'b1;
      cnt  = adder_lat;
      res  = fsum(add_a, add_b);
    end
  end

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (gnt != '0) begin
      g_q.push_back('{cyc, oh2idx(gnt)});
      if ($countones(gnt) != 1 || busy) viol++;
    end
    if (rsp_valid != '0) begin
      rsp_q.push_back('{cyc, oh2idx(rsp_valid), rsp_z, rsp_err});
      if ($countones(rsp_valid) != 1) viol++;
    end
    if (add_start) start_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa_r[i] = $realtobits((real'($urandom_range(0, 4000)) - 2000.0) * 0.25);
      opb_r[i] = $realtobits((real'($urandom_range(0, 4000)) - 2000.0) * 0.25);
    end
  endtask

  task automatic do_op(input logic [NREQ-1:0] mask, input int lat);
    int g0, r0, s0, n;
    g0 = g_q.size();
    r0 = rsp_q.size();
    s0 = start_q.size();
    adder_lat = lat;
    req = mask;
    op_reqcyc = cyc;
    op_ok = 1'b0;
    n = 0;
    while (g_q.size() == g0 && n < 20) begin step(); n++; end
    req = '0;
    n = 0;
    while (rsp_q.size() == r0 && n < 200) begin step(); n++; end
    if (g_q.size() > g0 && rsp_q.size() > r0 && start_q.size() > s0) begin
      op_ok = 1'b1;
      op_g  = g_q[g0];
      op_r  = rsp_q[r0];
      op_s  = start_q[s0];
    end
    step();
  endtask

  task automatic test_reset();
    rset = 1'b1;
    req  = '0;
    step();
    step();
    checks++;
    if ({gnt, rsp_valid, busy, add_start, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b rsp_valid=%b busy=%b start=%b err=%b want all 0",
               gnt, rsp_valid, busy, add_start, rsp_err);
    end
    checks++;
    if (rsp_z !== 64'h0) begin
      errors++;
      $display("FAIL reset_rsp_z: got %h want 0", rsp_z);
    end
    checks++;
    if ({add_a, add_b} !== 128'h0) begin
      errors++;
      $display("FAIL reset_operands: got a=%h b=%h want 0", add_a, add_b);
    end
    rset = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int g0, r0, n, exp;
    randomize_ops();
    adder_lat = 1;
    g0 = g_q.size();
    r0 = rsp_q.size();
    req = '1;
    n = 0;
    while (g_q.size() < g0 + 5 && n < 60) begin step(); n++; end
    req = '0;
    n = 0;
    while (rsp_q.size() < r0 + 5 && n < 60) begin step(); n++; end
    checks++;
    if (g_q.size() != g0 + 5 || rsp_q.size() != r0 + 5) begin
      errors++;
      $display("FAIL rr_count: got grants=%0d rsps=%0d want 5 and 5",
               g_q.size() - g0, rsp_q.size() - r0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        exp = model_pick('1, model_lg);
        checks++;
        if (g_q[g0+k].idx != exp || rsp_q[r0+k].idx != exp) begin
          errors++;
          $display("FAIL rr_order[%0d]: got gnt=%0d rsp=%0d want %0d",
                   k, g_q[g0+k].idx, rsp_q[r0+k].idx, exp);
        end
        checks++;
        if (rsp_q[r0+k].z !== fsum(opa_r[exp], opb_r[exp]) || rsp_q[r0+k].err !== 1'b0) begin
          errors++;
          $display("FAIL rr_sum[%0d]: got z=%h err=%b want z=%h err=0",
                   k, rsp_q[r0+k].z, rsp_q[r0+k].err, fsum(opa_r[exp], opb_r[exp]));
        end
        if (k > 0) begin
          checks++;
          if (g_q[g0+k].cyc - g_q[g0+k-1].cyc != 4) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles want 4",
                     k, g_q[g0+k].cyc - g_q[g0+k-1].cyc);
          end
        end
        model_lg = exp;
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL rr_onehot_busy: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_single();
    randomize_ops();
    opa_r[0] = 64'h3FF0000000000000;
    opb_r[0] = 64'h4000000000000000;
    do_op(4'b0001, 5);
    checks++;
    if (!op_ok) begin
      errors++;
      $display("FAIL single_done: got no response want one");
    end else begin
      checks++;
      if (op_g.idx != 0 || op_g.cyc != op_reqcyc) begin
        errors++;
        $display("FAIL single_gnt: got idx=%0d at +%0d want idx=0 at +0", op_g.idx, op_g.cyc - op_reqcyc);
      end
      checks++;
      if (op_s != op_g.cyc + 1) begin
        errors++;
        $display("FAIL single_start: got +%0d want +1", op_s - op_g.cyc);
      end
      checks++;
      if (op_r.cyc != op_g.cyc + 7 || op_r.idx != 0) begin
        errors++;
        $display("FAIL single_rsp: got idx=%0d at +%0d want idx=0 at +7", op_r.idx, op_r.cyc - op_g.cyc);
      end
      checks++;
      if (op_r.z !== 64'h4008000000000000 || op_r.err !== 1'b0) begin
        errors++;
        $display("FAIL single_z: got z=%h err=%b want z=4008000000000000 err=0", op_r.z, op_r.err);
      end
      model_lg = 0;
    end
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] masks [3];
    int exp;
    masks[0] = 4'b0100;
    masks[1] = 4'b0011;
    masks[2] = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      randomize_ops();
      do_op(masks[k], 2);
      exp = model_pick(masks[k], model_lg);
      checks++;
      if (!op_ok || op_g.idx != exp || op_r.idx != exp) begin
        errors++;
        $display("FAIL wrap_gnt[%0d]: got ok=%0d gnt=%0d rsp=%0d want %0d", k, op_ok, op_g.idx, op_r.idx, exp);
      end
      checks++;
      if (op_r.z !== fsum(opa_r[exp], opb_r[exp])) begin
        errors++;
        $display("FAIL wrap_z[%0d]: got %h want %h", k, op_r.z, fsum(opa_r[exp], opb_r[exp]));
      end
      model_lg = exp;
    end
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] m;
    int exp;
    randomize_ops();
    m = NREQ'(1) << $urandom_range(0, NREQ-1);
    do_op(m, 0);
    exp = model_pick(m, model_lg);
    checks++;
    if (!op_ok || op_r.idx != exp || op_r.cyc - op_s != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_timing: got ok=%0d idx=%0d delay=%0d want idx=%0d delay=%0d",
               op_ok, op_r.idx, op_r.cyc - op_s, exp, TIMEOUT);
    end
    checks++;
    if (op_r.err !== 1'b1 || op_r.z !== 64'h0) begin
      errors++;
      $display("FAIL timeout_err: got err=%b z=%h want err=1 z=0", op_r.err, op_r.z);
    end
    model_lg = exp;
    randomize_ops();
    m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    do_op(m, 3);
    exp = model_pick(m, model_lg);
    checks++;
    if (!op_ok || op_r.idx != exp || op_r.err !== 1'b0 || op_r.cyc != op_g.cyc + 5 ||
        op_r.z !== fsum(opa_r[exp], opb_r[exp])) begin
      errors++;
      $display("FAIL post_timeout: got ok=%0d idx=%0d err=%b lat=%0d z=%h want idx=%0d err=0 lat=5 z=%h",
               op_ok, op_r.idx, op_r.err, op_r.cyc - op_g.cyc, op_r.z, exp, fsum(opa_r[exp], opb_r[exp]));
    end
    model_lg = exp;
  endtask

  task automatic test_tie();
    logic [NREQ-1:0] m;
    logic [63:0] held;
    int exp, r0, s0;
    randomize_ops();
    m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    do_op(m, TIMEOUT - 1);
    exp = model_pick(m, model_lg);
    checks++;
    if (!op_ok || op_r.idx != exp || op_r.err !== 1'b0 || op_r.cyc - op_s != TIMEOUT ||
        op_r.z !== fsum(opa_r[exp], opb_r[exp])) begin
      errors++;
      $display("FAIL tie: got ok=%0d idx=%0d err=%b delay=%0d z=%h want idx=%0d err=0 delay=%0d z=%h",
               op_ok, op_r.idx, op_r.err, op_r.cyc - op_s, op_r.z, exp, TIMEOUT, fsum(opa_r[exp], opb_r[exp]));
    end
    model_lg = exp;
    held = fsum(opa_r[exp], opb_r[exp]);
    r0 = rsp_q.size();
    s0 = start_q.size();
    stray_z = {$urandom, $urandom};
    stray_cnt++;
    repeat (8) step();
    checks++;
    if (rsp_q.size() != r0 || start_q.size() != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: got rsps=%0d starts=%0d busy=%b want 0 0 0",
               rsp_q.size() - r0, start_q.size() - s0, busy);
    end
    checks++;
    if (rsp_z !== held || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rsp_hold: got z=%h err=%b want z=%h err=0", rsp_z, rsp_err, held);
    end
  endtask

  task automatic test_reset_mid();
    int g0, r0, s0, n;
    randomize_ops();
    adder_lat = 5;
    g0 = g_q.size();
    r0 = rsp_q.size();
    s0 = start_q.size();
    req = 4'b0010;
    n = 0;
    while (start_q.size() == s0 && n < 20) begin
      step();
      n++;
      if (g_q.size() > g0) req = '0;
    end
    req = '0;
    step();
    rset = 1'b1;
    step();
    rset = 1'b0;
    checks++;
    if ({gnt, rsp_valid, busy, add_start, rsp_err} !== '0 || rsp_z !== 64'h0 ||
        add_a !== 64'h0 || add_b !== 64'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got gnt=%b rv=%b busy=%b st=%b err=%b z=%h a=%h b=%h want all 0",
               gnt, rsp_valid, busy, add_start, rsp_err, rsp_z, add_a, add_b);
    end
    repeat (10) step();
    checks++;
    if (rsp_q.size() != r0 || start_q.size() != s0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_late_done: got rsps=%0d starts=%0d busy=%b want 0 1 0",
               rsp_q.size() - r0, start_q.size() - s0, busy);
    end
    model_lg = NREQ - 1;
    randomize_ops();
    do_op(4'b1000, 2);
    checks++;
    if (!op_ok || op_g.idx != 3 || op_g.cyc != op_reqcyc || op_r.idx != 3 ||
        op_r.z !== fsum(opa_r[3], opb_r[3])) begin
      errors++;
      $display("FAIL post_reset_op: got ok=%0d gnt=%0d at +%0d rsp=%0d z=%h want 3 at +0 rsp=3 z=%h",
               op_ok, op_g.idx, op_g.cyc - op_reqcyc, op_r.idx, op_r.z, fsum(opa_r[3], opb_r[3]));
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      opa_r[i] = '0;
      opb_r[i] = '0;
    end
    test_reset();
    model_lg = NREQ - 1;
    test_round_robin();
    test_single();
    test_wrap();
    test_timeout();
    test_tie();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
